// File: rtl/uart_cmd_sched_pkg.sv
// Shared types and constants for the serial command-frame scheduler.
// Holds FSM states, opcodes, status codes and the frame check helper.
package uart_cmd_sched_pkg;

   typedef enum logic [3:0] {
      S_HUNT,
      S_CMD,
      S_LENH,
      S_LENL,
      S_CSUM,
      S_ISSUE,
      S_WAIT,
      S_ACK,
      S_NAK
   } state_t;

   localparam logic [7:0] OP_LOOP   = 8'h01;
   localparam logic [7:0] OP_SDINIT = 8'h02;

   localparam logic [7:0] ST_GO = 8'h00;
   localparam logic [7:0] ST_E1 = 8'hE1;
   localparam logic [7:0] ST_E2 = 8'hE2;
   localparam logic [7:0] ST_E3 = 8'hE3;
   localparam logic [7:0] ST_E4 = 8'hE4;

   // ST_GO means the frame may be issued; otherwise the NAK code.
   function automatic logic [7:0] frame_status(
      input logic [7:0]  cmd,
      input logic [15:0] len,
      input logic [7:0]  csum
   );
      if (csum != (cmd ^ len[15:8] ^ len[7:0]))
         return ST_E1;
      if (cmd != OP_LOOP && cmd != OP_SDINIT)
         return ST_E2;
      if (cmd == OP_LOOP && len == 16'h0000)
         return ST_E2;
      return ST_GO;
   endfunction

endpackage

// File: rtl/uart_cmd_sched_if.sv
// Status-byte channel: valid/ready handshake carrying one byte.
// master: ack_valid, ack_data out, ack_ready in; slave: the reverse.
interface uart_cmd_sched_if;

   logic       ack_valid;
   logic [7:0] ack_data;
   logic       ack_ready;

   modport master (
      output ack_valid,
      output ack_data,
      input  ack_ready
   );

   modport slave (
      input  ack_valid,
      input  ack_data,
      output ack_ready
   );

endinterface

// File: rtl/uart_cmd_sched_timer.sv
// sched_timer: W-bit up-counter with clear, enable and limit compare.
// Ports: clk, rst_n, clr_i, en_i in; exp_o high while count == LIMIT.
module sched_timer #(
   parameter int unsigned W     = 32,
   parameter int unsigned LIMIT = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic exp_o
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign exp_o = (cnt_q == LIM);

   // Parks at the limit so expiry stays asserted until cleared.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !exp_o)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: parses HDR/CMD/LEN_H/LEN_L/CSUM frames from the UART,
// issues opcode+length to the sequencer, waits for done, returns status.
// Ports: clk, rst_n, rx_data/rx_valid in; cmd_out/len_out out;
// ctrl_done in; ack (status channel, master); sched_busy, drop_cnt out.
module uart_cmd_sched
   import uart_cmd_sched_pkg::*;
#(
   parameter logic [7:0]  HDR     = 8'hA5,
   parameter logic [7:0]  ACK_OK  = 8'h5A,
   parameter int unsigned BYTE_TO = 50000,
   parameter int unsigned EXEC_TO = 100000000,
   parameter int unsigned TO_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [7:0]       cmd_out,
   output logic [15:0]      len_out,
   input  logic             ctrl_done,
   uart_cmd_sched_if.master ack,
   output logic             sched_busy,
   output logic [7:0]       drop_cnt
);

   state_t      state_q;
   logic [7:0]  fcmd_q;
   logic [7:0]  flenh_q;
   logic [7:0]  flenl_q;
   logic [7:0]  cmd_q;
   logic [15:0] len_q;
   logic        ack_vld_q;
   logic [7:0]  ack_data_q;
   logic        busy_q;
   logic        done_q;
   logic [7:0]  drop_q;

   logic        in_frame;
   logic        drop_st;
   logic        done_rise;
   logic        byte_exp;
   logic        exec_exp;
   logic [7:0]  fstat;

   assign in_frame  = state_q inside {S_CMD, S_LENH, S_LENL, S_CSUM};
   assign drop_st   = state_q inside {S_ISSUE, S_WAIT, S_ACK, S_NAK};
   assign done_rise = ctrl_done & ~done_q;
   assign fstat     = frame_status(fcmd_q, {flenh_q, flenl_q}, rx_data);

   sched_timer #(
      .W     (TO_W),
      .LIMIT (BYTE_TO)
   ) u_byte_to (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (!in_frame || rx_valid),
      .en_i  (in_frame),
      .exp_o (byte_exp)
   );

   sched_timer #(
      .W     (TO_W),
      .LIMIT (EXEC_TO)
   ) u_exec_to (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (state_q != S_WAIT),
      .en_i  (state_q == S_WAIT),
      .exp_o (exec_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_HUNT;
         fcmd_q     <= '0;
         flenh_q    <= '0;
         flenl_q    <= '0;
         cmd_q      <= '0;
         len_q      <= '0;
         ack_vld_q  <= 1'b0;
         ack_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         drop_q     <= '0;
      end else begin
         done_q <= ctrl_done;
         if (rx_valid && drop_st && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
         // A byte landing on the expiry cycle wins over the timeout.
         if (in_frame && !rx_valid && byte_exp) begin
            state_q    <= S_NAK;
            ack_vld_q  <= 1'b1;
            ack_data_q <= ST_E4;
         end else begin
            unique case (state_q)
               S_HUNT:
                  if (rx_valid && rx_data == HDR) begin
                     state_q <= S_CMD;
                     busy_q  <= 1'b1;
                  end
               S_CMD:
                  if (rx_valid) begin
                     fcmd_q  <= rx_data;
                     state_q <= S_LENH;
                  end
               S_LENH:
                  if (rx_valid) begin
                     flenh_q <= rx_data;
                     state_q <= S_LENL;
                  end
               S_LENL:
                  if (rx_valid) begin
                     flenl_q <= rx_data;
                     state_q <= S_CSUM;
                  end
               S_CSUM:
                  if (rx_valid) begin
                     if (fstat == ST_GO) begin
                        state_q <= S_ISSUE;
                        cmd_q   <= fcmd_q;
                        len_q   <= {flenh_q, flenl_q};
                     end else begin
                        state_q    <= S_NAK;
                        ack_vld_q  <= 1'b1;
                        ack_data_q <= fstat;
                     end
                  end
               S_ISSUE: begin
                  cmd_q   <= '0;
                  state_q <= S_WAIT;
               end
               S_WAIT:
                  if (done_rise) begin
                     state_q    <= S_ACK;
                     ack_vld_q  <= 1'b1;
                     ack_data_q <= ACK_OK;
                  end else if (exec_exp) begin
                     state_q    <= S_NAK;
                     ack_vld_q  <= 1'b1;
                     ack_data_q <= ST_E3;
                  end
               S_ACK, S_NAK:
                  if (ack.ack_ready) begin
                     ack_vld_q <= 1'b0;
                     state_q   <= S_HUNT;
                     busy_q    <= 1'b0;
                  end
               default:
                  state_q <= S_HUNT;
            endcase
         end
      end
   end

   assign cmd_out       = cmd_q;
   assign len_out       = len_q;
   assign ack.ack_valid = ack_vld_q;
   assign ack.ack_data  = ack_data_q;
   assign sched_busy    = busy_q;
   assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Bench for uart_cmd_sched: directed frame table, multi-cycle corner
// sequences and random frames checked against a frame-rule model.
module tb_uart_cmd_sched;

   localparam int BYTE_TO = 100;
   localparam int EXEC_TO = 1000;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  cmd_out;
   logic [15:0] len_out;
   logic        ctrl_done;
   logic        sched_busy;
   logic [7:0]  drop_cnt;

   uart_cmd_sched_if ack_if();

   uart_cmd_sched #(
      .HDR     (8'hA5),
      .ACK_OK  (8'h5A),
      .BYTE_TO (BYTE_TO),
      .EXEC_TO (EXEC_TO),
      .TO_W    (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .cmd_out    (cmd_out),
      .len_out    (len_out),
      .ctrl_done  (ctrl_done),
      .ack        (ack_if.master),
      .sched_busy (sched_busy),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   int exp_drop = 0;
   logic [15:0] exp_len = 16'h0000;

   always @(negedge clk)
      if (cmd_out != 8'h00)
         pulses++;

   typedef struct {
      logic [7:0] c;
      logic [7:0] h;
      logic [7:0] l;
      logic [7:0] s;
      logic [7:0] st;
      int         nb;
      int         gidx;
      int         glen;
      int         dd;
   } vec_t;

   vec_t tv [12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] ref_status(input logic [7:0] c,
      input logic [7:0] h, input logic [7:0] l, input logic [7:0] s);
      logic sum_ok, op_ok, len_ok;
      sum_ok = ((c ^ h ^ l ^ s) == 8'h00);
      op_ok  = (c == 8'h01) || (c == 8'h02);
      len_ok = (c != 8'h01) || ((h | l) != 8'h00);
      if (!sum_ok)
         return 8'hE1;
      if (!(op_ok && len_ok))
         return 8'hE2;
      return 8'h5A;
   endfunction

   task automatic get_ack(input int maxc, input int rdly, output logic got,
                          output logic [7:0] d, output int w);
      got = 1'b0;
      d = 8'h00;
      w = 0;
      while (!got && w < maxc) begin
         if (ack_if.ack_valid === 1'b1)
            got = 1'b1;
         else begin
            tick();
            w++;
         end
      end
      if (got) begin
         d = ack_if.ack_data;
         for (int i = 0; i < rdly; i++) begin
            tick();
            chk("ack_hold", {ack_if.ack_valid, ack_if.ack_data}, {1'b1, d});
         end
         ack_if.ack_ready = 1'b1;
         tick();
         ack_if.ack_ready = 1'b0;
         chk("ack_clear", ack_if.ack_valid, 0);
         chk("idle_busy", sched_busy, 0);
      end
   endtask

   task automatic run_frame(input logic [7:0] c, input logic [7:0] h,
      input logic [7:0] l, input logic [7:0] s, input logic [7:0] expc,
      input int nb, input int gidx, input int glen, input int dd,
      input int rdly, input bit inj);
      logic [7:0] b [5];
      logic       got;
      logic [7:0] d;
      int         w;
      b[0] = 8'hA5;
      b[1] = c;
      b[2] = h;
      b[3] = l;
      b[4] = s;
      pulses = 0;
      for (int i = 0; i < nb; i++)
         send_one(b[i], (i == gidx) ? glen : int'($urandom_range(0, 2)));
      if (expc == 8'h5A) begin
         chk("issue_cmd", cmd_out, c);
         chk("issue_len", len_out, {h, l});
         chk("issue_busy", sched_busy, 1);
         exp_len = {h, l};
         tick();
         chk("cmd_back0", cmd_out, 0);
         chk("len_hold", len_out, exp_len);
         for (int i = 0; i < dd; i++) begin
            if (inj && $urandom_range(0, 3) == 0) begin
               rx_valid = 1'b1;
               rx_data  = 8'($urandom);
               if (exp_drop < 255)
                  exp_drop++;
            end
            tick();
            rx_valid = 1'b0;
         end
         ctrl_done = 1'b1;
      end
      get_ack(BYTE_TO + EXEC_TO + 50, rdly, got, d, w);
      ctrl_done = 1'b0;
      chk("ack_seen", got, 1);
      chk("ack_data", d, expc);
      if (expc == 8'hE4)
         chk("e4_latency", (w >= BYTE_TO && w <= BYTE_TO + 2), 1);
      chk("pulse_cnt", pulses, (expc == 8'h5A) ? 1 : 0);
      chk("len_after", len_out, exp_len);
      chk("drop_cnt", drop_cnt, exp_drop);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      logic       got;
      logic [7:0] d;
      int         w;
      logic [7:0] c, h, l, s, ex;
      int         nb, gidx, glen;

      rst_n = 1'b0;
      rx_data = 8'h00;
      rx_valid = 1'b0;
      ctrl_done = 1'b0;
      ack_if.ack_ready = 1'b0;

      tv[0]  = '{8'h01, 8'h00, 8'h04, 8'h05, 8'h5A, 5, -1, 0, 200};
      tv[1]  = '{8'h01, 8'h00, 8'h04, 8'h07, 8'hE1, 5, -1, 0, 0};
      tv[2]  = '{8'h03, 8'h00, 8'h01, 8'h02, 8'hE2, 5, -1, 0, 0};
      tv[3]  = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hE2, 5, -1, 0, 0};
      tv[4]  = '{8'h01, 8'h00, 8'h04, 8'h05, 8'h5A, 5, 3, BYTE_TO, 5};
      tv[5]  = '{8'h01, 8'h00, 8'h04, 8'h05, 8'hE4, 2, -1, 0, 0};
      tv[6]  = '{8'h02, 8'h00, 8'h00, 8'h02, 8'h5A, 5, -1, 0, 0};
      tv[7]  = '{8'h02, 8'h12, 8'h34, 8'h24, 8'h5A, 5, -1, 0, 30};
      tv[8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE2, 5, -1, 0, 0};
      tv[9]  = '{8'h01, 8'hFF, 8'hFF, 8'h01, 8'h5A, 5, -1, 0, 10};
      tv[10] = '{8'h02, 8'h00, 8'h00, 8'h03, 8'hE1, 5, -1, 0, 0};
      tv[11] = '{8'h03, 8'h00, 8'h01, 8'h03, 8'hE1, 5, 1, BYTE_TO, 0};

      repeat (3) tick();
      chk("rst_cmd", cmd_out, 0);
      chk("rst_len", len_out, 0);
      chk("rst_ackv", ack_if.ack_valid, 0);
      chk("rst_ackd", ack_if.ack_data, 0);
      chk("rst_busy", sched_busy, 0);
      chk("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++)
         run_frame(tv[i].c, tv[i].h, tv[i].l, tv[i].s, tv[i].st, tv[i].nb,
                   tv[i].gidx, tv[i].glen, tv[i].dd, i % 3, 1'b0);

      // Done already high at issue: no edge, exec timeout must fire.
      ctrl_done = 1'b1;
      repeat (2) tick();
      pulses = 0;
      send_one(8'hA5, 0);
      send_one(8'h02, 0);
      send_one(8'h00, 0);
      send_one(8'h00, 0);
      send_one(8'h02, 0);
      chk("e3_issue", cmd_out, 8'h02);
      exp_len = 16'h0000;
      get_ack(EXEC_TO + 50, 0, got, d, w);
      ctrl_done = 1'b0;
      chk("e3_seen", got, 1);
      chk("e3_code", d, 8'hE3);
      chk("e3_latency", (w >= EXEC_TO && w <= EXEC_TO + 3), 1);
      chk("e3_pulses", pulses, 1);

      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) begin
            c = 8'($urandom);
            if (c == 8'hA5)
               c = 8'h00;
            send_one(c, int'($urandom_range(0, 3)));
         end
         case ($urandom_range(0, 3))
            0: c = 8'h01;
            1: c = 8'h02;
            2: c = 8'h03;
            default: c = 8'($urandom);
         endcase
         h = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
         l = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
         s = c ^ h ^ l;
         if ($urandom_range(0, 3) == 0)
            s = s ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0) begin
            nb = int'($urandom_range(1, 4));
            gidx = -1;
            glen = 0;
            ex = 8'hE4;
         end else begin
            nb = 5;
            gidx = int'($urandom_range(1, 4));
            glen = ($urandom_range(0, 1) == 1) ? BYTE_TO :
                   int'($urandom_range(0, 10));
            ex = ref_status(c, h, l, s);
         end
         run_frame(c, h, l, s, ex, nb, gidx, glen,
                   int'($urandom_range(0, 60)),
                   int'($urandom_range(0, 3)), 1'b1);
      end

      // Flood the drop counter while waiting for done.
      pulses = 0;
      send_one(8'hA5, 0);
      send_one(8'h01, 0);
      send_one(8'h00, 0);
      send_one(8'h10, 0);
      send_one(8'h11, 0);
      chk("sat_issue", cmd_out, 8'h01);
      exp_len = 16'h0010;
      tick();
      for (int i = 0; i < 300; i++) begin
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
         tick();
      end
      rx_valid = 1'b0;
      exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
      chk("drop_sat", drop_cnt, exp_drop);
      chk("sat_busy", sched_busy, 1);
      chk("sat_ackv", ack_if.ack_valid, 0);
      ctrl_done = 1'b1;
      get_ack(EXEC_TO, 1, got, d, w);
      ctrl_done = 1'b0;
      chk("sat_seen", got, 1);
      chk("sat_code", d, 8'h5A);
      chk("sat_pulses", pulses, 1);
      chk("sat_len", len_out, exp_len);
      run_frame(8'h02, 8'hAB, 8'hCD, 8'h02 ^ 8'hAB ^ 8'hCD, 8'h5A,
                5, -1, 0, 7, 0, 1'b0);

      // Async reset while waiting for done.
      send_one(8'hA5, 0);
      send_one(8'h01, 0);
      send_one(8'h00, 0);
      send_one(8'h08, 0);
      send_one(8'h09, 0);
      chk("r1_issue", cmd_out, 8'h01);
      repeat (2) tick();
      chk("r1_busy", sched_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("r1_cmd", cmd_out, 0);
      chk("r1_len", len_out, 0);
      chk("r1_ackv", ack_if.ack_valid, 0);
      chk("r1_ackd", ack_if.ack_data, 0);
      chk("r1_busy0", sched_busy, 0);
      chk("r1_drop", drop_cnt, 0);
      #1 rst_n = 1'b1;
      exp_drop = 0;
      exp_len = 16'h0000;
      ctrl_done = 1'b1;
      repeat (5) tick();
      ctrl_done = 1'b0;
      chk("r1_noack", ack_if.ack_valid, 0);
      chk("r1_idle", sched_busy, 0);
      run_frame(8'h02, 8'h00, 8'h05, 8'h07, 8'h5A, 5, -1, 0, 3, 0, 1'b0);

      // Async reset while a NAK is held for lack of ready.
      send_one(8'hA5, 0);
      send_one(8'h01, 0);
      send_one(8'h00, 0);
      send_one(8'h04, 0);
      send_one(8'h07, 0);
      w = 0;
      while (ack_if.ack_valid !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      chk("r2_valid", ack_if.ack_valid, 1);
      chk("r2_code", ack_if.ack_data, 8'hE1);
      repeat (3) tick();
      chk("r2_hold", {ack_if.ack_valid, ack_if.ack_data}, {1'b1, 8'hE1});
      rst_n = 1'b0;
      #1;
      chk("r2_ackv", ack_if.ack_valid, 0);
      chk("r2_ackd", ack_if.ack_data, 0);
      chk("r2_busy", sched_busy, 0);
      chk("r2_len", len_out, 0);
      #1 rst_n = 1'b1;
      tick();
      run_frame(8'h01, 8'h00, 8'h04, 8'h05, 8'h5A, 5, -1, 0, 20, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
